// File: rtl/pool2d_unit.sv
// 2x2 / stride-2 max or average pooling over a raster-order, channel-interleaved frame.
// Horizontal pairs are reduced first; even rows park pair results in a line buffer.
module pool2d_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned CH     = 1,
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     pool_mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int unsigned OUT_W    = IMG_W / 2;
  localparam int unsigned OUT_H    = IMG_H / 2;
  localparam int unsigned LB_DEPTH = OUT_W * CH;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam bit          ODD_W    = (IMG_W % 2) == 1;
  localparam bit          ODD_H    = (IMG_H % 2) == 1;

  logic [CH_W-1:0]          ch_q;
  logic [COL_W-1:0]         col_q;
  logic [ROW_W-1:0]         row_q;
  logic                     mode_q;
  logic signed [DATA_W-1:0] left_q [CH];
  logic signed [DATA_W:0]   lb_q [LB_DEPTH];

  logic ch_last, col_last, row_last, frame_start;
  logic col_hold, col_pair, row_store, row_out;
  logic accept, fire, fire_last;
  logic signed [DATA_W-1:0] left;
  logic signed [DATA_W:0]   left_x, cur_x, pair, line, mx;
  logic signed [DATA_W+1:0] sum;
  logic [LB_AW-1:0]         lb_addr;
  logic [DATA_W-1:0]        result;
  logic                     unused_bits;

  always_comb begin
    ch_last     = ch_q == CH_W'(CH - 1);
    col_last    = col_q == COL_W'(IMG_W - 1);
    row_last    = row_q == ROW_W'(IMG_H - 1);
    frame_start = (ch_q == '0) && (col_q == '0) && (row_q == '0);
    // The trailing column/row of an odd dimension is counted but never pooled.
    col_hold    = !col_q[0] && !(ODD_W && col_last);
    col_pair    = col_q[0];
    row_store   = !row_q[0] && !(ODD_H && row_last);
    row_out     = row_q[0];
    accept      = in_valid && !clear;

    left   = left_q[ch_q];
    left_x = {left[DATA_W-1], left};
    cur_x  = {in_data[DATA_W-1], in_data};
    if (mode_q) pair = left_x + cur_x;
    else        pair = (left_x > cur_x) ? left_x : cur_x;

    lb_addr = LB_AW'(col_q >> 1) * LB_AW'(CH) + LB_AW'(ch_q);
    line    = lb_q[lb_addr];
    sum     = {pair[DATA_W], pair} + {line[DATA_W], line};
    mx      = (pair > line) ? pair : line;
    // sum[DATA_W+1:2] is the floor-divided-by-4 average.
    result  = mode_q ? sum[DATA_W+1:2] : mx[DATA_W-1:0];

    fire      = accept && col_pair && row_out;
    fire_last = fire && ch_last && (col_q == COL_W'(2 * OUT_W - 1)) &&
                (row_q == ROW_W'(2 * OUT_H - 1));
  end

  assign unused_bits = ^{sum[1:0], mx[DATA_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      for (int i = 0; i < int'(CH); i++) left_q[i] <= '0;
    end else begin
      out_valid  <= fire;
      out_last   <= fire_last;
      frame_done <= accept && ch_last && col_last && row_last;
      if (fire) begin
        out_data <= result;
        out_ch   <= ch_q;
      end
      if (clear) begin
        ch_q  <= '0;
        col_q <= '0;
        row_q <= '0;
      end else if (in_valid) begin
        if (frame_start) mode_q <= pool_mode;
        if (col_hold) left_q[ch_q] <= in_data;
        if (ch_last) begin
          ch_q <= '0;
          if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
    end
  end

  // Every entry read in an odd row was written in the preceding even row, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept && col_pair && row_store) lb_q[lb_addr] <= pair;
  end

endmodule

// File: tb/tb_pool2d_unit.sv
// Bench for pool2d_unit: a 28x28x1 instance and a 5x5x2 instance checked against a
// window-level pooling model, plus hand-computed literal expectations.
module tb_pool2d_unit;

  localparam int AW = 28, AH = 28, BW = 5, BH = 5, BCH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_clear, a_mode, a_valid, a_out_valid, a_out_last, a_frame_done;
  logic signed [7:0] a_data, a_out_data;
  logic [0:0] a_out_ch;
  logic b_clear, b_mode, b_valid, b_out_valid, b_out_last, b_frame_done;
  logic signed [7:0] b_data, b_out_data;
  logic [0:0] b_out_ch;

  pool2d_unit u_dut (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .pool_mode(a_mode), .in_valid(a_valid),
    .in_data(a_data), .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_last(a_out_last), .frame_done(a_frame_done)
  );

  pool2d_unit #(.DATA_W(8), .IMG_W(BW), .IMG_H(BH), .CH(BCH)) u_odd (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .pool_mode(b_mode), .in_valid(b_valid),
    .in_data(b_data), .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_last(b_out_last), .frame_done(b_frame_done)
  );

  typedef struct {int data; int ch; bit last;} exp_t;
  exp_t exp_a[$], exp_b[$];
  int fa [AW*AH];
  int fb [BW*BH*BCH];
  int cap_a [256];
  int cap_b [32];
  int n_a, n_b, fd_a, fd_b;
  int held_a, held_ach, held_b, held_bch;
  int n_cmp, n_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int samp(input int which, input int idx);
    return (which != 0) ? fb[idx] : fa[idx];
  endfunction

  // Expected outputs of a frame from its 2x2 windows; only windows whose last sample
  // (index < nsent) was actually delivered produce an output.
  task automatic model_push(input int which, input int mode, input int nsent);
    int w, h, nc, m;
    int v [4];
    exp_t e;
    w  = (which != 0) ? BW : AW;
    h  = (which != 0) ? BH : AH;
    nc = (which != 0) ? BCH : 1;
    for (int i = 0; i < h / 2; i++)
      for (int j = 0; j < w / 2; j++)
        for (int c = 0; c < nc; c++)
          if (((2*i+1)*w + 2*j+1)*nc + c < nsent) begin
            v[0] = samp(which, ((2*i)*w   + 2*j)*nc   + c);
            v[1] = samp(which, ((2*i)*w   + 2*j+1)*nc + c);
            v[2] = samp(which, ((2*i+1)*w + 2*j)*nc   + c);
            v[3] = samp(which, ((2*i+1)*w + 2*j+1)*nc + c);
            if (mode != 0) begin
              e.data = (v[0] + v[1] + v[2] + v[3]) >>> 2;
            end else begin
              m = v[0];
              for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
              e.data = m;
            end
            e.ch   = c;
            e.last = (i == h/2 - 1) && (j == w/2 - 1) && (c == nc - 1);
            if (which != 0) exp_b.push_back(e);
            else            exp_a.push_back(e);
          end
  endtask

  task automatic drive_a(input int n, input int gap_max, input int toggle_at);
    for (int k = 0; k < n; k++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(posedge clk); #1 a_valid = 1'b0;
      end
      @(posedge clk); #1;
      a_valid = 1'b1;
      a_data  = 8'(fa[k]);
      if (k == toggle_at) a_mode = ~a_mode;
    end
    @(posedge clk); #1 a_valid = 1'b0;
  endtask

  task automatic drive_b(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      b_valid = 1'b1;
      b_data  = 8'(fb[k]);
    end
    @(posedge clk); #1 b_valid = 1'b0;
  endtask

  task automatic fill_random_a();
    for (int k = 0; k < AW*AH; k++) fa[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Single compare process for both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_output", int'(a_out_valid), 0);
        end else begin
          exp_t e;
          e = exp_a.pop_front();
          chk("a_data", int'(a_out_data), e.data);
          chk("a_ch", int'(a_out_ch), e.ch);
          chk("a_last", int'(a_out_last), int'(e.last));
          held_a   = e.data;
          held_ach = e.ch;
        end
        if (n_a < 256) cap_a[n_a] = int'(a_out_data);
        n_a++;
      end else begin
        chk("a_hold_data", int'(a_out_data), held_a);
        chk("a_hold_ch", int'(a_out_ch), held_ach);
        chk("a_idle_last", int'(a_out_last), 0);
      end
      if (b_out_valid) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_output", int'(b_out_valid), 0);
        end else begin
          exp_t e;
          e = exp_b.pop_front();
          chk("b_data", int'(b_out_data), e.data);
          chk("b_ch", int'(b_out_ch), e.ch);
          chk("b_last", int'(b_out_last), int'(e.last));
          held_b   = e.data;
          held_bch = e.ch;
        end
        if (n_b < 32) cap_b[n_b] = int'(b_out_data);
        n_b++;
      end else begin
        chk("b_hold_data", int'(b_out_data), held_b);
        chk("b_hold_ch", int'(b_out_ch), held_bch);
        chk("b_idle_last", int'(b_out_last), 0);
      end
      if (a_frame_done) fd_a++;
      if (b_frame_done) fd_b++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d expected outputs pending",
             exp_a.size() + exp_b.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    a_clear = 1'b0; a_mode = 1'b0; a_valid = 1'b0; a_data = '0;
    b_clear = 1'b0; b_mode = 1'b0; b_valid = 1'b0; b_data = '0;
    held_a = 0; held_ach = 0; held_b = 0; held_bch = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(a_out_valid), 0);
    chk("reset_out_data", int'(a_out_data), 0);
    chk("reset_out_last", int'(a_out_last), 0);
    chk("reset_frame_done", int'(a_frame_done), 0);
    chk("reset_b_out_data", int'(b_out_data), 0);
    rst_n = 1'b1;

    // Max mode, (r*28+c) mod 128 pattern.
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) fa[r*AW + c] = (r*28 + c) % 128;
    n_a = 0;
    model_push(0, 0, AW*AH);
    drive_a(AW*AH, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("max_count", n_a, 196);
    chk("max_out0", cap_a[0], 29);
    chk("max_out13", cap_a[13], 55);
    chk("max_out14", cap_a[14], 85);
    chk("max_frame_done", fd_a, 1);

    // Abort after 100 samples; a sample coinciding with clear is dropped.
    fill_random_a();
    model_push(0, 0, 100);
    drive_a(100, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    a_clear = 1'b1; a_valid = 1'b1; a_data = 8'sd55;
    @(posedge clk); #1;
    a_clear = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", int'(a_out_valid), 0);
    chk("clear_frame_done", int'(a_frame_done), 0);

    // Full frame after clear; pool_mode flips mid-frame but the frame stays max.
    @(posedge clk); #1;
    fill_random_a();
    n_a = 0;
    model_push(0, 0, AW*AH);
    drive_a(AW*AH, 0, 400);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_frame_count", n_a, 196);
    chk("clear_frame_done_cnt", fd_a, 2);

    // Average frame (mode now 1) with saturating and negative corner windows.
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) fa[r*AW + c] = ((r*5 + c*3) % 64) - 32;
    fa[0] = -1;  fa[1] = -2;  fa[AW] = -3;  fa[AW+1] = -4;
    fa[2] = 127; fa[3] = 127; fa[AW+2] = 127; fa[AW+3] = 127;
    fa[4] = -128; fa[5] = -128; fa[AW+4] = -128; fa[AW+5] = -128;
    n_a = 0;
    model_push(0, 1, AW*AH);
    drive_a(AW*AH, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("avg_neg_floor", cap_a[0], -3);
    chk("avg_pos_max", cap_a[1], 127);
    chk("avg_neg_min", cap_a[2], -128);
    chk("avg_count", n_a, 196);

    // Two frames with random input gaps.
    a_mode = 1'b0;
    fill_random_a();
    model_push(0, 0, AW*AH);
    drive_a(AW*AH, 5, -1);
    fill_random_a();
    model_push(0, 0, AW*AH);
    drive_a(AW*AH, 5, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_frame_done_cnt", fd_a, 5);

    // Reset pulse mid-frame.
    fill_random_a();
    model_push(0, 0, 150);
    drive_a(150, 0, -1);
    #1;
    rst_n = 1'b0;
    exp_a.delete();
    exp_b.delete();
    held_a = 0; held_ach = 0; held_b = 0; held_bch = 0;
    #1;
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_data", int'(a_out_data), 0);
    chk("rst_out_last", int'(a_out_last), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    fill_random_a();
    n_a = 0;
    model_push(0, 0, AW*AH);
    drive_a(AW*AH, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_count", n_a, 196);
    chk("rst_frame_done_cnt", fd_a, 6);

    // Odd 5x5x2 frame: column 4 and row 4 carry 127 and must never matter.
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        for (int ch = 0; ch < BCH; ch++)
          fb[(r*BW + c)*BCH + ch] = (c == 4 || r == 4) ? 127 : r*10 + c*2 + ch;
    n_b = 0;
    model_push(1, 0, BW*BH*BCH);
    drive_b(BW*BH*BCH);
    @(negedge clk);
    chk("odd_frame_done_timing", int'(b_frame_done), 1);
    @(negedge clk);
    chk("odd_frame_done_width", int'(b_frame_done), 0);
    @(posedge clk); #1;
    b_mode = 1'b1;
    model_push(1, 1, BW*BH*BCH);
    drive_b(BW*BH*BCH);
    repeat (3) @(posedge clk);
    #1;
    chk("odd_count", n_b, 16);
    chk("odd_out0", cap_b[0], 12);
    chk("odd_out1", cap_b[1], 13);
    chk("odd_out7", cap_b[7], 37);
    chk("odd_frame_done_cnt", fd_b, 2);

    repeat (5) @(posedge clk);
    #1;
    chk("a_pending_outputs", exp_a.size(), 0);
    chk("b_pending_outputs", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
